fptd_iteration_ctrl: RTL

- Schedules one lower-decoder frame in the fully parallel turbo decoder.
- Accepts a frame-start handshake and clears the section state registers.
- Drives the alternating odd/even/termination enables for a programmed number of iterations.
- At frame end, reports the bit-error count taken from the decoder's b1_error vector with a done pulse.

---
 rtl/fptd_iteration_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fptd_iteration_ctrl.sv
// fptd_iteration_ctrl: schedules one lower-decoder frame of the fully parallel turbo decoder.
//
// A frame is: CLEAR (nClear low) -> {ODD, EVEN} x lim -> DONE -> IDLE. Each iteration takes exactly
// two cycles. At the edge entering DONE, err_count captures popcount(b1_error).
//
// Optional feature (define FPTD_EARLY_STOP_EN): the frame ends early once the hard decisions stay
// unchanged across two consecutive iteration boundaries. If the macro is undefined, hard_bits is
// unused and early_stop stays 0. The port list is the same in both builds.
//
// Ports:
//   Clock        in   system clock, rising edge
//   nReset       in   asynchronous active-low reset
//   start        in   frame start request, accepted only while ready=1
//   iter_limit   in   iterations to run (0 is treated as 1), sampled on start acceptance
//   b1_error     in   per-bit error flags from the lower decoder
//   hard_bits    in   per-bit hard decisions (early-stop build only)
//   ready        out  high in IDLE
//   nClear       out  active-low synchronous clear to decoder sections (CLEAR cycle)
//   Enable_Odd   out  odd-section enable
//   Enable_Even  out  even-section enable
//   Enable_Term  out  termination-section enable (with Enable_Odd)
//   iter_count   out  completed iterations of the current/last frame
//   done         out  one-cycle pulse at frame end
//   err_count    out  popcount(b1_error) captured at frame end
//   early_stop   out  set with done if the frame ended before its limit
module fptd_iteration_ctrl #(
  parameter int unsigned FL     = 40,
  parameter int unsigned ITER_W = 6,
  parameter int unsigned ERR_W  = 6
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_limit,
  input  logic [FL-1:0]     b1_error,
  input  logic [FL-1:0]     hard_bits,
  output logic              ready,
  output logic              nClear,
  output logic              Enable_Odd,
  output logic              Enable_Even,
  output logic              Enable_Term,
  output logic [ITER_W-1:0] iter_count,
  output logic              done,
  output logic [ERR_W-1:0]  err_count,
  output logic              early_stop
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StOdd,
    StEven,
    StDone
  } state_e;

  state_e            state;
  logic [ITER_W-1:0] lim;
  logic [ITER_W-1:0] iter_next;
  logic              last_iter;
  logic [ERR_W-1:0]  err_pop;
  logic              stop_now;

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < int'(FL); i++) begin
      err_pop = err_pop + ERR_W'(b1_error[i]);
    end
  end

  assign iter_next = iter_count + ITER_W'(1);
  assign last_iter = (iter_next == lim);

`ifdef FPTD_EARLY_STOP_EN
  logic [FL-1:0] prev_bits;
  logic [1:0]    stable_cnt;
  logic [1:0]    stable_next;

  // The first boundary has nothing meaningful to compare against, hence the iter_count gate.
  always_comb begin
    stable_next = 2'd0;
    if ((hard_bits == prev_bits) && (iter_count != '0)) begin
      stable_next = stable_cnt + 2'd1;
    end
  end

  assign stop_now = (stable_next == 2'd2);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      prev_bits  <= '0;
      stable_cnt <= 2'd0;
    end else if (state == StClear) begin
      prev_bits  <= '0;
      stable_cnt <= 2'd0;
    end else if (state == StEven) begin
      prev_bits  <= hard_bits;
      stable_cnt <= stable_next;
    end
  end
`else
  logic unused_hard_bits;
  assign unused_hard_bits = ^hard_bits;
  assign stop_now         = 1'b0;
`endif

  // Single FSM; every output is a flop updated together with the state.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= StIdle;
      lim         <= ITER_W'(1);
      ready       <= 1'b1;
      nClear      <= 1'b1;
      Enable_Odd  <= 1'b0;
      Enable_Even <= 1'b0;
      Enable_Term <= 1'b0;
      iter_count  <= '0;
      done        <= 1'b0;
      err_count   <= '0;
      early_stop  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            lim        <= (iter_limit == '0) ? ITER_W'(1) : iter_limit;
            iter_count <= '0;
            ready      <= 1'b0;
            nClear     <= 1'b0;
            state      <= StClear;
          end
        end
        StClear: begin
          nClear      <= 1'b1;
          Enable_Odd  <= 1'b1;
          Enable_Term <= 1'b1;
          state       <= StOdd;
        end
        StOdd: begin
          Enable_Odd  <= 1'b0;
          Enable_Term <= 1'b0;
          Enable_Even <= 1'b1;
          state       <= StEven;
        end
        StEven: begin
          Enable_Even <= 1'b0;
          iter_count  <= iter_next;
          if (last_iter || stop_now) begin
            done       <= 1'b1;
            err_count  <= err_pop;
            early_stop <= stop_now && !last_iter;
            state      <= StDone;
          end else begin
            Enable_Odd  <= 1'b1;
            Enable_Term <= 1'b1;
            state       <= StOdd;
          end
        end
        StDone: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
